// File: rtl/spi_slave_sync_18bit.sv
// SPI peripheral for the far end of the 18-bit SPI master link.
// SCLK, CS_n and MOSI are oversampled in the i_Clk domain.
module spi_slave_sync_18bit #(
    parameter int SPI_MODE = 0,
    parameter int BIT_PER_TRANSFER = 18,
    parameter logic [BIT_PER_TRANSFER-1:0] TX_IDLE_WORD = '0
) (
    input  logic                        i_Clk,
    input  logic                        i_Rst,
    input  logic [BIT_PER_TRANSFER-1:0] i_TX_Word,
    input  logic                        i_TX_DV,
    output logic                        o_TX_Ready,
    output logic                        o_RX_DV,
    output logic [BIT_PER_TRANSFER-1:0] o_RX_Word,
    output logic                        o_TX_Underrun,
    output logic                        o_Frame_Err,
    input  logic                        i_SPI_Clk,
    input  logic                        i_SPI_CS_n,
    input  logic                        i_SPI_MOSI,
    output logic                        o_SPI_MISO,
    output logic                        o_SPI_MISO_En,
    output logic [5:0]                  o_debug_BitCount
);

    localparam int BPT = BIT_PER_TRANSFER;
    localparam logic CPOL = (SPI_MODE >= 2);
    localparam logic CPHA = ((SPI_MODE % 2) == 1);
    localparam logic [5:0] LAST = 6'(BPT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state;
    logic [2:0]     sclk_q;
    logic [1:0]     cs_q;
    logic [1:0]     mosi_q;
    logic [5:0]     bitcnt;
    logic [BPT-1:0] txsh;
    logic [BPT-1:0] txsh_next;
    logic [BPT-1:0] rxsh;
    logic [BPT-1:0] hold;
    logic           rise;
    logic           fall;
    logic           sample_edge;
    logic           shift_edge;
    logic           cs_sync;
    logic           mosi_sync;
    logic           load;

    assign rise        = sclk_q[1] & ~sclk_q[2];
    assign fall        = ~sclk_q[1] & sclk_q[2];
    assign cs_sync     = cs_q[1];
    assign mosi_sync   = mosi_q[1];
    // lead is the edge away from CPOL, trail the one back to it
    assign sample_edge = CPHA ? (CPOL ? rise : fall) : (CPOL ? fall : rise);
    assign shift_edge  = CPHA ? (CPOL ? fall : rise) : (CPOL ? rise : fall);

    assign o_debug_BitCount = bitcnt;

    always_comb begin
        load      = 1'b0;
        txsh_next = txsh;
        if (state == IDLE) begin
            load = ~cs_sync;
        end else if (!cs_sync) begin
            if (CPHA) load = sample_edge && (bitcnt == 6'd0);
            else      load = shift_edge && (bitcnt == LAST);
        end
        if (load) begin
            txsh_next = o_TX_Ready ? TX_IDLE_WORD : hold;
        end else if (state == SHIFT && !cs_sync && shift_edge &&
                     !(CPHA && bitcnt == LAST)) begin
            txsh_next = {txsh[BPT-2:0], 1'b0};
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= IDLE;
            bitcnt        <= LAST;
            sclk_q        <= {3{CPOL}};
            cs_q          <= 2'b11;
            mosi_q        <= 2'b00;
            txsh          <= '0;
            rxsh          <= '0;
            hold          <= '0;
            o_TX_Ready    <= 1'b1;
            o_RX_DV       <= 1'b0;
            o_RX_Word     <= '0;
            o_TX_Underrun <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            o_SPI_MISO_En <= 1'b0;
        end else begin
            sclk_q        <= {sclk_q[1:0], i_SPI_Clk};
            cs_q          <= {cs_q[0], i_SPI_CS_n};
            mosi_q        <= {mosi_q[0], i_SPI_MOSI};
            o_RX_DV       <= 1'b0;
            o_Frame_Err   <= 1'b0;
            o_TX_Underrun <= load & o_TX_Ready;
            txsh          <= txsh_next;
            if (load) o_TX_Ready <= 1'b1;
            // a same-cycle accept wins over the load emptying the register
            if (i_TX_DV && o_TX_Ready) begin
                hold       <= i_TX_Word;
                o_TX_Ready <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    o_SPI_MISO    <= 1'b0;
                    o_SPI_MISO_En <= 1'b0;
                    if (!cs_sync) begin
                        state         <= SHIFT;
                        bitcnt        <= LAST;
                        o_SPI_MISO    <= txsh_next[BPT-1];
                        o_SPI_MISO_En <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_sync) begin
                        state         <= IDLE;
                        o_SPI_MISO    <= 1'b0;
                        o_SPI_MISO_En <= 1'b0;
                        if (bitcnt != LAST) o_Frame_Err <= 1'b1;
                        bitcnt        <= LAST;
                    end else begin
                        o_SPI_MISO <= txsh_next[BPT-1];
                        if (sample_edge) begin
                            rxsh <= {rxsh[BPT-2:0], mosi_sync};
                            if (bitcnt == 6'd0) begin
                                o_RX_Word <= {rxsh[BPT-2:0], mosi_sync};
                                o_RX_DV   <= 1'b1;
                                bitcnt    <= LAST;
                            end else begin
                                bitcnt <= bitcnt - 6'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_sync_18bit.sv
// Directed bench for spi_slave_sync_18bit.
// One MODE0 instance (idle word 3FFFF) and one MODE3 instance.
module tb_spi_slave_sync_18bit;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic sclk0, cs0, mosi0, tx_dv0;
    logic [17:0] tx_word0, rxw0;
    logic ready0, rxdv0, unr0, ferr0, miso0, en0;
    logic [5:0] bc0;

    logic sclk3, cs3, mosi3, tx_dv3;
    logic [17:0] tx_word3, rxw3;
    logic ready3, rxdv3, unr3, ferr3, miso3, en3;
    logic [5:0] bc3;

    spi_slave_sync_18bit #(
        .SPI_MODE(0), .BIT_PER_TRANSFER(18), .TX_IDLE_WORD(18'h3FFFF)
    ) u_m0 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_Word(tx_word0), .i_TX_DV(tx_dv0), .o_TX_Ready(ready0),
        .o_RX_DV(rxdv0), .o_RX_Word(rxw0),
        .o_TX_Underrun(unr0), .o_Frame_Err(ferr0),
        .i_SPI_Clk(sclk0), .i_SPI_CS_n(cs0), .i_SPI_MOSI(mosi0),
        .o_SPI_MISO(miso0), .o_SPI_MISO_En(en0),
        .o_debug_BitCount(bc0)
    );

    spi_slave_sync_18bit #(
        .SPI_MODE(3), .BIT_PER_TRANSFER(18), .TX_IDLE_WORD(18'h0)
    ) u_m3 (
        .i_Clk(clk), .i_Rst(rst),
        .i_TX_Word(tx_word3), .i_TX_DV(tx_dv3), .o_TX_Ready(ready3),
        .o_RX_DV(rxdv3), .o_RX_Word(rxw3),
        .o_TX_Underrun(unr3), .o_Frame_Err(ferr3),
        .i_SPI_Clk(sclk3), .i_SPI_CS_n(cs3), .i_SPI_MOSI(mosi3),
        .o_SPI_MISO(miso3), .o_SPI_MISO_En(en3),
        .o_debug_BitCount(bc3)
    );

    int compared = 0;
    int mismatched = 0;

    int n_rx0 = 0, n_unr0 = 0, n_fe0 = 0;
    int n_rx3 = 0, n_unr3 = 0, n_fe3 = 0;
    logic [17:0] log3 [0:7];

    always @(negedge clk) begin
        if (rxdv0) n_rx0 <= n_rx0 + 1;
        if (unr0)  n_unr0 <= n_unr0 + 1;
        if (ferr0) n_fe0 <= n_fe0 + 1;
        if (rxdv3) begin
            log3[n_rx3 % 8] <= rxw3;
            n_rx3 <= n_rx3 + 1;
        end
        if (unr3)  n_unr3 <= n_unr3 + 1;
        if (ferr3) n_fe3 <= n_fe3 + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push0(input logic [17:0] w);
        tx_word0 = w;
        tx_dv0 = 1'b1;
        @(negedge clk);
        tx_dv0 = 1'b0;
    endtask

    // MODE0 master: drive MOSI before rise, sample MISO on rise.
    // CS_n is raised before SCLK returns low so no trailing edge is seen.
    task automatic xfer0(input logic [17:0] w, input int n, input bit fin,
                         output logic [17:0] r, output logic en_seen);
        r = '0;
        en_seen = 1'b0;
        cs0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi0 = w[17-i];
            wait_clks(HALF);
            sclk0 = 1'b1;
            r = {r[16:0], miso0};
            if (i == 0) en_seen = en0;
            wait_clks(HALF);
            if (i < n - 1) sclk0 = 1'b0;
        end
        if (fin) begin
            cs0 = 1'b1;
            wait_clks(HALF);
            sclk0 = 1'b0;
            wait_clks(HALF);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        compared++; if (ready0 !== 1'b1) begin mismatched++; $display("FAIL rst_ready0: got %b want 1", ready0); end
        compared++; if (rxdv0 !== 1'b0) begin mismatched++; $display("FAIL rst_rxdv0: got %b want 0", rxdv0); end
        compared++; if (rxw0 !== 18'h0) begin mismatched++; $display("FAIL rst_rxword0: got %h want 00000", rxw0); end
        compared++; if (unr0 !== 1'b0) begin mismatched++; $display("FAIL rst_unr0: got %b want 0", unr0); end
        compared++; if (ferr0 !== 1'b0) begin mismatched++; $display("FAIL rst_ferr0: got %b want 0", ferr0); end
        compared++; if (miso0 !== 1'b0) begin mismatched++; $display("FAIL rst_miso0: got %b want 0", miso0); end
        compared++; if (en0 !== 1'b0) begin mismatched++; $display("FAIL rst_en0: got %b want 0", en0); end
        compared++; if (bc0 !== 6'd17) begin mismatched++; $display("FAIL rst_bitcnt0: got %0d want 17", bc0); end
        compared++; if (ready3 !== 1'b1) begin mismatched++; $display("FAIL rst_ready3: got %b want 1", ready3); end
        compared++; if (en3 !== 1'b0) begin mismatched++; $display("FAIL rst_en3: got %b want 0", en3); end
        compared++; if (bc3 !== 6'd17) begin mismatched++; $display("FAIL rst_bitcnt3: got %0d want 17", bc3); end
    endtask

    task automatic test_basic;
        logic [17:0] r;
        logic en;
        int rx_b, unr_b, fe_b;
        push0(18'h15A5A);
        compared++; if (ready0 !== 1'b0) begin mismatched++; $display("FAIL t1_ready_full: got %b want 0", ready0); end
        rx_b = n_rx0; unr_b = n_unr0; fe_b = n_fe0;
        xfer0(18'h2A5A5, 18, 1'b1, r, en);
        wait_clks(4);
        compared++; if (en !== 1'b1) begin mismatched++; $display("FAIL t1_miso_en: got %b want 1", en); end
        compared++; if (rxw0 !== 18'h2A5A5) begin mismatched++; $display("FAIL t1_rx_word: got %h want 2a5a5", rxw0); end
        compared++; if (r !== 18'h15A5A) begin mismatched++; $display("FAIL t1_master_rx: got %h want 15a5a", r); end
        compared++; if (n_rx0 - rx_b !== 1) begin mismatched++; $display("FAIL t1_rxdv_count: got %0d want 1", n_rx0 - rx_b); end
        compared++; if (n_unr0 - unr_b !== 0) begin mismatched++; $display("FAIL t1_underrun: got %0d want 0", n_unr0 - unr_b); end
        compared++; if (n_fe0 - fe_b !== 0) begin mismatched++; $display("FAIL t1_frame_err: got %0d want 0", n_fe0 - fe_b); end
        compared++; if (ready0 !== 1'b1) begin mismatched++; $display("FAIL t1_ready_after: got %b want 1", ready0); end
        compared++; if (en0 !== 1'b0) begin mismatched++; $display("FAIL t1_en_idle: got %b want 0", en0); end
    endtask

    task automatic test_multi;
        logic [17:0] mo [0:2];
        logic [17:0] mi [0:2];
        logic [17:0] r [0:2];
        int rx_b, unr_b, fe_b;
        mo[0] = 18'h3C3C3; mo[1] = 18'h00001; mo[2] = 18'h20000;
        mi[0] = 18'h12345; mi[1] = 18'h2AAAA; mi[2] = 18'h15555;
        tx_word3 = mi[0];
        tx_dv3 = 1'b1;
        @(negedge clk);
        tx_dv3 = 1'b0;
        rx_b = n_rx3; unr_b = n_unr3; fe_b = n_fe3;
        fork
            begin
                cs3 = 1'b0;
                wait_clks(HALF);
                for (int k = 0; k < 3; k++) begin
                    r[k] = '0;
                    for (int i = 0; i < 18; i++) begin
                        sclk3 = 1'b0;
                        mosi3 = mo[k][17-i];
                        wait_clks(HALF);
                        sclk3 = 1'b1;
                        r[k] = {r[k][16:0], miso3};
                        wait_clks(HALF);
                    end
                end
                cs3 = 1'b1;
                wait_clks(HALF);
            end
            begin
                for (int k = 1; k < 3; k++) begin
                    int t;
                    t = 0;
                    while (ready3 !== 1'b1 && t < 2000) begin
                        @(negedge clk);
                        t++;
                    end
                    if (t >= 2000) begin
                        compared++;
                        mismatched++;
                        $display("FAIL t2_ready_timeout: got 0 want 1");
                    end
                    tx_word3 = mi[k];
                    tx_dv3 = 1'b1;
                    @(negedge clk);
                    tx_dv3 = 1'b0;
                end
            end
        join
        wait_clks(4);
        compared++; if (n_rx3 - rx_b !== 3) begin mismatched++; $display("FAIL t2_rxdv_count: got %0d want 3", n_rx3 - rx_b); end
        for (int k = 0; k < 3; k++) begin
            compared++; if (log3[(rx_b + k) % 8] !== mo[k]) begin mismatched++; $display("FAIL t2_rx_word%0d: got %h want %h", k, log3[(rx_b + k) % 8], mo[k]); end
            compared++; if (r[k] !== mi[k]) begin mismatched++; $display("FAIL t2_master_rx%0d: got %h want %h", k, r[k], mi[k]); end
        end
        compared++; if (n_unr3 - unr_b !== 1) begin mismatched++; $display("FAIL t2_underrun: got %0d want 1", n_unr3 - unr_b); end
        compared++; if (n_fe3 - fe_b !== 0) begin mismatched++; $display("FAIL t2_frame_err: got %0d want 0", n_fe3 - fe_b); end
    endtask

    task automatic test_underrun;
        logic [17:0] r;
        logic en;
        int unr_b;
        unr_b = n_unr0;
        xfer0(18'h00F0F, 18, 1'b1, r, en);
        wait_clks(4);
        compared++; if (n_unr0 - unr_b !== 1) begin mismatched++; $display("FAIL t3_underrun: got %0d want 1", n_unr0 - unr_b); end
        compared++; if (r !== 18'h3FFFF) begin mismatched++; $display("FAIL t3_master_rx: got %h want 3ffff", r); end
        compared++; if (rxw0 !== 18'h00F0F) begin mismatched++; $display("FAIL t3_rx_word: got %h want 00f0f", rxw0); end
    endtask

    task automatic test_frame_err;
        logic [17:0] r;
        logic en;
        int rx_b, fe_b;
        push0(18'h0AAAA);
        rx_b = n_rx0; fe_b = n_fe0;
        xfer0(18'h3FFFF, 9, 1'b1, r, en);
        wait_clks(4);
        compared++; if (n_fe0 - fe_b !== 1) begin mismatched++; $display("FAIL t4_frame_err: got %0d want 1", n_fe0 - fe_b); end
        compared++; if (n_rx0 - rx_b !== 0) begin mismatched++; $display("FAIL t4_no_rxdv: got %0d want 0", n_rx0 - rx_b); end
        compared++; if (rxw0 !== 18'h00F0F) begin mismatched++; $display("FAIL t4_word_kept: got %h want 00f0f", rxw0); end
        push0(18'h11111);
        rx_b = n_rx0;
        xfer0(18'h25A5A, 18, 1'b1, r, en);
        wait_clks(4);
        compared++; if (rxw0 !== 18'h25A5A) begin mismatched++; $display("FAIL t4_next_rx: got %h want 25a5a", rxw0); end
        compared++; if (r !== 18'h11111) begin mismatched++; $display("FAIL t4_next_master_rx: got %h want 11111", r); end
        compared++; if (n_rx0 - rx_b !== 1) begin mismatched++; $display("FAIL t4_next_rxdv: got %0d want 1", n_rx0 - rx_b); end
    endtask

    task automatic test_reset_mid;
        logic [17:0] r;
        logic en;
        int rx_b, fe_b, unr_b;
        push0(18'h33333);
        xfer0(18'h3FFFF, 5, 1'b0, r, en);
        rst = 1'b1;
        wait_clks(2);
        compared++; if (ready0 !== 1'b1) begin mismatched++; $display("FAIL t5_ready: got %b want 1", ready0); end
        compared++; if (rxw0 !== 18'h0) begin mismatched++; $display("FAIL t5_rx_word: got %h want 00000", rxw0); end
        compared++; if (miso0 !== 1'b0 || en0 !== 1'b0) begin mismatched++; $display("FAIL t5_miso: got %b%b want 00", miso0, en0); end
        compared++; if (bc0 !== 6'd17) begin mismatched++; $display("FAIL t5_bitcnt: got %0d want 17", bc0); end
        cs0 = 1'b1;
        sclk0 = 1'b0;
        wait_clks(4);
        rx_b = n_rx0; fe_b = n_fe0; unr_b = n_unr0;
        rst = 1'b0;
        wait_clks(8);
        compared++; if (n_fe0 - fe_b !== 0 || n_rx0 - rx_b !== 0) begin mismatched++; $display("FAIL t5_no_pulses: got fe=%0d rx=%0d want 0 0", n_fe0 - fe_b, n_rx0 - rx_b); end
        push0(18'h0F0F0);
        xfer0(18'h1E1E1, 18, 1'b1, r, en);
        wait_clks(4);
        compared++; if (rxw0 !== 18'h1E1E1) begin mismatched++; $display("FAIL t5_next_rx: got %h want 1e1e1", rxw0); end
        compared++; if (r !== 18'h0F0F0) begin mismatched++; $display("FAIL t5_next_master_rx: got %h want 0f0f0", r); end
        compared++; if (n_unr0 - unr_b !== 0) begin mismatched++; $display("FAIL t5_underrun: got %0d want 0", n_unr0 - unr_b); end
    endtask

    task automatic test_ignore;
        logic [17:0] r;
        logic en;
        int unr_b;
        push0(18'h2D2D2);
        compared++; if (ready0 !== 1'b0) begin mismatched++; $display("FAIL t6_ready_first: got %b want 0", ready0); end
        push0(18'h00FFF);
        compared++; if (ready0 !== 1'b0) begin mismatched++; $display("FAIL t6_ready_second: got %b want 0", ready0); end
        unr_b = n_unr0;
        xfer0(18'h30003, 18, 1'b1, r, en);
        wait_clks(4);
        compared++; if (r !== 18'h2D2D2) begin mismatched++; $display("FAIL t6_master_rx: got %h want 2d2d2", r); end
        compared++; if (ready0 !== 1'b1) begin mismatched++; $display("FAIL t6_ready_after: got %b want 1", ready0); end
        compared++; if (n_unr0 - unr_b !== 0) begin mismatched++; $display("FAIL t6_underrun: got %0d want 0", n_unr0 - unr_b); end
        compared++; if (rxw0 !== 18'h30003) begin mismatched++; $display("FAIL t6_rx_word: got %h want 30003", rxw0); end
    endtask

    initial begin
        rst = 1'b1;
        sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
        tx_dv0 = 1'b0; tx_word0 = '0;
        sclk3 = 1'b1; cs3 = 1'b1; mosi3 = 1'b0;
        tx_dv3 = 1'b0; tx_word3 = '0;
        test_reset();
        test_basic();
        test_multi();
        test_underrun();
        test_frame_err();
        test_reset_mid();
        test_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
